// File: rtl/dsd_lab3_seq.sv
// rtl/dsd_lab3_seq.sv - exhaustive 3-input sweep tester for a combinational x/y logic block
// Drives each vector for HOLD_CYCLES, samples once, and records mismatch count and first failing index.
module dsd_lab3_seq #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] x_exp_map,
    input  logic [7:0] y_exp_map,
    input  logic       x_in,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] fail_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] err_count_q, err_count_d;
    logic       fail_valid_q, fail_valid_d;
    logic [2:0] fail_idx_q, fail_idx_d;
    logic       mismatch;

    assign mismatch = (x_in != x_exp_map[vec_q]) || (y_in != y_exp_map[vec_q]);

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        hold_cnt_d   = hold_cnt_q;
        err_count_d  = err_count_q;
        fail_valid_d = fail_valid_q;
        fail_idx_d   = fail_idx_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && !abort) begin
                    state_d      = S_DRIVE;
                    vec_d        = 3'd0;
                    hold_cnt_d   = 8'd0;
                    err_count_d  = 4'd0;
                    fail_valid_d = 1'b0;
                    fail_idx_d   = 3'd0;
                end
            end
            S_DRIVE: begin
                if (abort) begin
                    state_d    = S_IDLE;
                    vec_d      = 3'd0;
                    hold_cnt_d = 8'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = S_SAMPLE;
                    end
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    // aborted sample is discarded, results stay frozen
                    state_d    = S_IDLE;
                    vec_d      = 3'd0;
                    hold_cnt_d = 8'd0;
                end else begin
                    if (mismatch) begin
                        err_count_d = err_count_q + 4'd1;
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            fail_idx_d   = vec_q;
                        end
                    end
                    if (vec_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_DRIVE;
                        vec_d      = vec_q + 3'd1;
                        hold_cnt_d = 8'd0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vec_q        <= 3'd0;
            hold_cnt_q   <= 8'd0;
            err_count_q  <= 4'd0;
            fail_valid_q <= 1'b0;
            fail_idx_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            hold_cnt_q   <= hold_cnt_d;
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            fail_idx_q   <= fail_idx_d;
        end
    end

    assign busy       = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    assign done       = (state_q == S_DONE);
    assign pass       = done && (err_count_q == 4'd0);
    assign {a, b, c}  = busy ? vec_q : 3'd0;
    assign err_count  = err_count_q;
    assign fail_valid = fail_valid_q;
    assign fail_idx   = fail_idx_q;

endmodule

// File: tb/tb_dsd_lab3_seq.sv
// tb/tb_dsd_lab3_seq.sv - directed bench for dsd_lab3_seq with a majority/parity reference block
module tb_dsd_lab3_seq;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [7:0] x_exp_map, y_exp_map;
    logic       x_in, y_in;
    logic       a, b, c, busy, done, pass, fail_valid;
    logic [3:0] err_count;
    logic [2:0] fail_idx;
    logic       x_stuck0, y_inv;
    int         tests = 0;
    int         fails = 0;

    dsd_lab3_seq #(.HOLD_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .x_exp_map(x_exp_map), .y_exp_map(y_exp_map),
        .x_in(x_in), .y_in(y_in),
        .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_valid(fail_valid), .fail_idx(fail_idx)
    );

    always #5 clk = ~clk;

    // block under test: x = majority, y = parity, with optional faults
    assign x_in = x_stuck0 ? 1'b0 : ((a & b) | (a & c) | (b & c));
    assign y_in = y_inv ? ~(a ^ b ^ c) : (a ^ b ^ c);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        got = {a, b, c, busy, done, pass, err_count, fail_valid, fail_idx};
        tests++;
        if (got !== 14'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%h exp=0", got);
        end
    endtask

    task automatic test_correct_sweep();
        logic [2:0] ev;
        logic [2:0] got_v;
        x_stuck0 = 1'b0;
        y_inv    = 1'b0;
        do_start();
        for (int k = 0; k < 24; k++) begin
            if (k > 0) step();
            ev    = 3'(k / 3);
            got_v = {a, b, c};
            tests++;
            if (got_v !== ev || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL sweep_vec k=%0d abc=%0d busy=%b done=%b exp abc=%0d busy=1 done=0",
                         k, got_v, busy, done, ev);
            end
        end
        step();
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || err_count !== 4'd0 ||
            fail_valid !== 1'b0 || {a, b, c} !== 3'd0) begin
            fails++;
            $display("FAIL good_done done=%b busy=%b pass=%b err=%0d fv=%b abc=%0d exp 1 0 1 0 0 0",
                     done, busy, pass, err_count, fail_valid, {a, b, c});
        end
        repeat (3) step();
        tests++;
        if (done !== 1'b1 || pass !== 1'b1 || err_count !== 4'd0) begin
            fails++;
            $display("FAIL done_hold done=%b pass=%b err=%0d exp 1 1 0", done, pass, err_count);
        end
    endtask

    task automatic test_x_stuck();
        x_stuck0 = 1'b1;
        y_inv    = 1'b0;
        do_start();
        repeat (23) step();
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL xstuck_early_done done=%b exp 0", done);
        end
        step();
        tests++;
        if (done !== 1'b1 || err_count !== 4'd4 || fail_valid !== 1'b1 ||
            fail_idx !== 3'd3 || pass !== 1'b0) begin
            fails++;
            $display("FAIL xstuck_result done=%b err=%0d fv=%b idx=%0d pass=%b exp 1 4 1 3 0",
                     done, err_count, fail_valid, fail_idx, pass);
        end
    endtask

    task automatic test_y_inv();
        x_stuck0 = 1'b0;
        y_inv    = 1'b1;
        do_start();
        tests++;
        if (err_count !== 4'd0 || fail_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL restart_clear err=%0d fv=%b busy=%b exp 0 0 1", err_count, fail_valid, busy);
        end
        repeat (24) step();
        tests++;
        if (done !== 1'b1 || err_count !== 4'd8 || fail_idx !== 3'd0 ||
            fail_valid !== 1'b1 || pass !== 1'b0) begin
            fails++;
            $display("FAIL yinv_result done=%b err=%0d idx=%0d fv=%b pass=%b exp 1 8 0 1 0",
                     done, err_count, fail_idx, fail_valid, pass);
        end
        y_inv = 1'b0;
    endtask

    task automatic test_start_ignored();
        x_stuck0 = 1'b0;
        y_inv    = 1'b0;
        do_start();
        repeat (4) step();
        @(negedge clk);
        start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if ({a, b, c} !== 3'd1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL start_busy abc=%0d busy=%b exp 1 1", {a, b, c}, busy);
        end
        repeat (18) step();
        tests++;
        if (done !== 1'b0 || {a, b, c} !== 3'd7) begin
            fails++;
            $display("FAIL start_busy_k23 done=%b abc=%0d exp 0 7", done, {a, b, c});
        end
        step();
        tests++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            fails++;
            $display("FAIL start_busy_done done=%b pass=%b exp 1 1", done, pass);
        end
    endtask

    task automatic test_abort();
        do_start();
        repeat (9) step();
        @(negedge clk);
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests++;
        if (busy !== 1'b0 || {a, b, c} !== 3'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle busy=%b abc=%0d done=%b exp 0 0 0", busy, {a, b, c}, done);
        end
        repeat (5) step();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_stay busy=%b done=%b exp 0 0", busy, done);
        end
        do_start();
        tests++;
        if ({a, b, c} !== 3'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_restart abc=%0d busy=%b exp 0 1", {a, b, c}, busy);
        end
        repeat (23) step();
        tests++;
        if (done !== 1'b0) begin
            fail_print_early: begin
                fails++;
                $display("FAIL abort_restart_early done=%b exp 0", done);
            end
        end
        step();
        tests++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            fails++;
            $display("FAIL abort_restart_done done=%b pass=%b exp 1 1", done, pass);
        end
    endtask

    task automatic test_abort_in_sample();
        x_stuck0 = 1'b1;
        do_start();
        repeat (11) step();
        tests++;
        if ({a, b, c} !== 3'd3) begin
            fails++;
            $display("FAIL abort_sample_vec abc=%0d exp 3", {a, b, c});
        end
        @(negedge clk);
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests++;
        if (err_count !== 4'd0 || fail_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_sample_freeze err=%0d fv=%b busy=%b exp 0 0 0",
                     err_count, fail_valid, busy);
        end
        x_stuck0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [13:0] got;
        x_stuck0 = 1'b1;
        do_start();
        repeat (12) step();
        tests++;
        if (err_count !== 4'd1 || fail_valid !== 1'b1 || fail_idx !== 3'd3 || {a, b, c} !== 3'd4) begin
            fails++;
            $display("FAIL pre_rst err=%0d fv=%b idx=%0d abc=%0d exp 1 1 3 4",
                     err_count, fail_valid, fail_idx, {a, b, c});
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        rst = 1'b0;
        got = {a, b, c, busy, done, pass, err_count, fail_valid, fail_idx};
        tests++;
        if (got !== 14'd0) begin
            fails++;
            $display("FAIL mid_rst got=%h exp=0", got);
        end
        x_stuck0 = 1'b0;
        do_start();
        tests++;
        if ({a, b, c} !== 3'd0 || busy !== 1'b1 || err_count !== 4'd0) begin
            fails++;
            $display("FAIL post_rst_start abc=%0d busy=%b err=%0d exp 0 1 0", {a, b, c}, busy, err_count);
        end
        repeat (24) step();
        tests++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            fails++;
            $display("FAIL post_rst_done done=%b pass=%b exp 1 1", done, pass);
        end
    endtask

    task automatic test_rst_start();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            fails++;
            $display("FAIL rst_start busy=%b done=%b pass=%b exp 0 0 0", busy, done, pass);
        end
        step();
        tests++;
        if (busy !== 1'b0 || {a, b, c} !== 3'd0) begin
            fails++;
            $display("FAIL rst_start_stay busy=%b abc=%0d exp 0 0", busy, {a, b, c});
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        x_exp_map = 8'hE8;
        y_exp_map = 8'h96;
        x_stuck0  = 1'b0;
        y_inv     = 1'b0;
        test_reset();
        test_correct_sweep();
        test_x_stuck();
        test_y_inv();
        test_start_ignored();
        test_abort();
        test_abort_in_sample();
        test_reset_mid();
        test_rst_start();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
